// File: rtl/multicycle_datapath.sv
// Multi-cycle CPU core: PC, IR, GPR file, ALU and a FETCH/DECODE/EXEC/MEM/WB sequencer.
// Zero-wait latency in cycles: BEQ 3, SD 4, ALU/ADDI 4, LD 5. Each memory wait cycle adds one.
// Backpressure: imem_req and dmem_req are held until the matching ack, so wait-state memories stall the FSM.
// Ports: clk/rst (async, active-low); run (start/continue); imem_* fetch handshake;
//        dmem_* load/store handshake; Opcode/pc_out/halted/retired status.
module multicycle_datapath #(
    parameter int          Bits     = 32,
    parameter int          N        = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [Bits-1:0]  dmem_addr,
    output logic [Bits-1:0]  dmem_wdata,
    input  logic [Bits-1:0]  dmem_rdata,
    input  logic             dmem_ack,
    output logic [2:0]       Opcode,
    output logic [31:0]      pc_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = $clog2(N);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_SD   = 3'b110;
    localparam logic [2:0] OP_BEQ  = 3'b111;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     ir;
    logic [Bits-1:0] gpr [N];
    logic [Bits-1:0] opa;
    logic [Bits-1:0] opb;
    logic [Bits-1:0] alu_q;   // ALU result; reused as load-data holder between MEM and WB
    logic [Bits-1:0] alu;

    // Instruction field decode straight from IR
    logic [2:0]         op;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      rs1_idx;
    logic [AW-1:0]      rs2_idx;
    logic signed [11:0] imm_i12;
    logic signed [11:0] imm_s12;
    logic [Bits-1:0]    imm_i;
    logic [Bits-1:0]    imm_s;
    logic [31:0]        br_off;
    logic [Bits-1:0]    rs1_val;
    logic [Bits-1:0]    rs2_val;
    logic               unused_ir_bits;

    assign op      = ir[2:0];
    assign rd_idx  = ir[7 +: AW];
    assign rs1_idx = ir[15 +: AW];
    assign rs2_idx = ir[20 +: AW];
    assign imm_i12 = ir[31:20];
    assign imm_s12 = {ir[31:25], ir[11:7]};
    assign imm_i   = Bits'(imm_i12);
    assign imm_s   = Bits'(imm_s12);
    assign br_off  = 32'(imm_s12);
    assign unused_ir_bits = ^{ir[6:3], ir[14:12], ir[19:15]};

    // Index 0 is hard-wired to zero on read
    assign rs1_val = (rs1_idx == '0) ? '0 : gpr[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : gpr[rs2_idx];

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:        alu = opa + opb;
            OP_SUB:        alu = opa - opb;
            OP_AND:        alu = opa & opb;
            OP_OR:         alu = opa | opb;
            OP_ADDI,
            OP_LD:         alu = opa + imm_i;
            OP_SD:         alu = opa + imm_s;
            default:       alu = '0;
        endcase
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            alu_q   <= '0;
            retired <= '0;
            for (int i = 0; i < N; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= (imem_rdata == HALT_WORD) ? S_HALT : S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= rs1_val;
                    opb   <= rs2_val;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q <= alu;
                    if (op == OP_BEQ && opa == opb) pc <= pc + 32'd4 + br_off;
                    else                            pc <= pc + 32'd4;
                    if (op == OP_BEQ) begin
                        retired <= sat_inc(retired);
                        state   <= run ? S_FETCH : S_IDLE;
                    end else if (op == OP_LD || op == OP_SD) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LD) begin
                            alu_q <= dmem_rdata;
                            state <= S_WB;
                        end else begin
                            retired <= sat_inc(retired);
                            state   <= run ? S_FETCH : S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    if (rd_idx != '0) gpr[rd_idx] <= alu_q;
                    retired <= sat_inc(retired);
                    state   <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode directly from registered state,
    // so an async reset drops any pending request at once.
    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && (op == OP_SD);
    assign dmem_addr  = alu_q;
    assign dmem_wdata = opb;
    assign Opcode     = op;
    assign pc_out     = pc;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_datapath.sv
`timescale 1ns/1ps
module tb_multicycle_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, run2;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
    logic [2:0]  Opcode;
    logic [15:0] retired;

    logic        imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2, halted2;
    logic [31:0] imem_addr2, imem_rdata2, dmem_addr2, dmem_wdata2, dmem_rdata2, pc_out2;
    logic [2:0]  Opcode2;
    logic [1:0]  retired2;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int iwait = 0, dwait = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct packed { logic [31:0] addr; logic [31:0] dat; } st_t;
    st_t sb_q [$];

    multicycle_datapath u_dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .Opcode(Opcode), .pc_out(pc_out), .halted(halted), .retired(retired)
    );

    multicycle_datapath #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .run(run2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ack(imem_ack2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_rdata(dmem_rdata2), .dmem_ack(dmem_ack2),
        .Opcode(Opcode2), .pc_out(pc_out2), .halted(halted2), .retired(retired2)
    );

    // Second core: zero-wait memories wired combinationally
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = imem[imem_addr2[7:2]];
    assign dmem_ack2   = dmem_req2;
    assign dmem_rdata2 = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] f_r(input logic [2:0] op, input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 4'b0, op};
    endfunction
    function automatic logic [31:0] f_i(input logic [2:0] op, input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b0, rd, 4'b0, op};
    endfunction
    function automatic logic [31:0] f_s(input logic [2:0] op, input logic [4:0] rs1, rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b0, imm[4:0], 4'b0, op};
    endfunction

    task automatic push_st(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a;
        e.dat  = d;
        sb_q.push_back(e);
    endtask

    // Memory responder for the main core: ack after iwait/dwait extra cycles
    initial begin
        int icnt = 0, dcnt = 0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                if (icnt >= iwait) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:2]]; end
                else begin imem_ack = 1'b0; icnt++; end
            end else begin imem_ack = 1'b0; icnt = 0; end
            if (dmem_req) begin
                if (dcnt >= dwait) begin dmem_ack = 1'b1; dmem_rdata = dmem[dmem_addr[7:2]]; end
                else begin dmem_ack = 1'b0; dcnt++; end
            end else begin dmem_ack = 1'b0; dcnt = 0; end
        end
    end

    // Store monitor / scoreboard checker
    initial begin
        forever begin
            @(negedge clk);
            if (rst && dmem_req && dmem_ack && dmem_we) begin
                dmem[dmem_addr[7:2]] = dmem_wdata;
                if (sb_q.size() == 0) begin
                    check("unexpected_store_addr", dmem_addr, 32'hDEAD_0000);
                end else begin
                    st_t e;
                    e = sb_q.pop_front();
                    check("store_addr", dmem_addr, e.addr);
                    check("store_data", dmem_wdata, e.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'hFFFF_FFFF;
            dmem[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        run = 1'b0; run2 = 1'b0;
        @(negedge clk); rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        clear_prog();
    endtask

    task automatic count_to(input string nm, input int k, output int n);
        n = 0;
        while (retired != 16'(k) && n < 200) begin tick(); n++; end
        check(nm, 32'(retired), 32'(k));
    endtask

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!halted && n < 300) begin tick(); n++; end
        check(nm, 32'(halted), 32'd1);
    endtask

    initial begin
        int n;
        int req_seen;
        rst = 1'b0; run = 1'b0; run2 = 1'b0;
        clear_prog();
        tick(); tick(); tick();
        check("rst_pc", pc_out, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_dmem_bus", {dmem_addr[15:0], dmem_wdata[15:0]}, 32'h0);
        rst = 1'b1;
        tick();
        check("idle_no_fetch", 32'(imem_req), 32'd0);

        // T1: ADDI/ADDI/ADD, zero-wait, 12 cycles
        imem[0] = f_i(3'b100, 5'd1, 5'd0, 12'd5);
        imem[1] = f_i(3'b100, 5'd2, 5'd0, 12'hFFD);
        imem[2] = f_r(3'b000, 5'd3, 5'd1, 5'd2);
        imem[3] = f_s(3'b110, 5'd0, 5'd3, 12'd0);
        push_st(32'd0, 32'd2);
        run = 1'b1;
        n = 0;
        while (!imem_req && n < 10) begin tick(); n++; end
        check("t1_first_fetch", 32'(imem_req), 32'd1);
        count_to("t1_retire3", 3, n);
        check("t1_latency", 32'(n), 32'd12);
        wait_halt("t1_halt");
        check("t1_retired", 32'(retired), 32'd4);
        check("t1_pc", pc_out, 32'h10);
        check("t1_opcode", 32'(Opcode), 32'd7);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // T2: SD then LD with 3 dmem wait cycles
        do_reset();
        dwait = 3;
        imem[0] = f_i(3'b100, 5'd1, 5'd0, 12'd5);
        imem[1] = f_s(3'b110, 5'd0, 5'd1, 12'd8);
        imem[2] = f_i(3'b101, 5'd4, 5'd0, 12'd8);
        imem[3] = f_s(3'b110, 5'd0, 5'd4, 12'd12);
        push_st(32'd8, 32'd5);
        push_st(32'd12, 32'd5);
        run = 1'b1;
        count_to("t2_retire1", 1, n);
        count_to("t2_retire2", 2, n);
        check("t2_sd_latency", 32'(n), 32'd7);
        count_to("t2_retire3", 3, n);
        check("t2_ld_latency", 32'(n), 32'd8);
        wait_halt("t2_halt");
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        dwait = 0;

        // T3a/T4: taken BEQ at 0x10, x0 write discarded, HALT at 0x20
        do_reset();
        imem[0] = f_i(3'b100, 5'd1, 5'd0, 12'd5);
        imem[1] = f_i(3'b100, 5'd2, 5'd0, 12'hFFD);
        imem[2] = f_i(3'b100, 5'd0, 5'd0, 12'd7);
        imem[3] = f_s(3'b110, 5'd0, 5'd0, 12'd16);
        imem[4] = f_s(3'b111, 5'd1, 5'd1, 12'd8);
        imem[5] = f_s(3'b110, 5'd0, 5'd1, 12'd24);
        imem[6] = f_s(3'b110, 5'd0, 5'd1, 12'd28);
        imem[7] = f_s(3'b110, 5'd0, 5'd2, 12'd20);
        push_st(32'd16, 32'd0);
        push_st(32'd20, 32'hFFFF_FFFD);
        run = 1'b1;
        count_to("t3_retire5", 5, n);
        check("t3_beq_taken_pc", pc_out, 32'h1C);
        wait_halt("t4_halt");
        req_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (imem_req || dmem_req) req_seen++;
        end
        check("t4_no_req", 32'(req_seen), 32'd0);
        check("t4_pc_frozen", pc_out, 32'h20);
        check("t4_retired_frozen", 32'(retired), 32'd6);
        check("t4_still_halted", 32'(halted), 32'd1);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // T3b: untaken BEQ at 0x10
        do_reset();
        imem[0] = f_i(3'b100, 5'd1, 5'd0, 12'd5);
        imem[1] = f_i(3'b100, 5'd2, 5'd0, 12'hFFD);
        imem[2] = f_i(3'b100, 5'd0, 5'd0, 12'd7);
        imem[3] = f_s(3'b110, 5'd0, 5'd0, 12'd16);
        imem[4] = f_s(3'b111, 5'd1, 5'd2, 12'd8);
        imem[5] = f_s(3'b110, 5'd0, 5'd1, 12'd24);
        imem[6] = f_s(3'b110, 5'd0, 5'd1, 12'd28);
        imem[7] = f_s(3'b110, 5'd0, 5'd2, 12'd20);
        push_st(32'd16, 32'd0);
        push_st(32'd24, 32'd5);
        push_st(32'd28, 32'd5);
        push_st(32'd20, 32'hFFFF_FFFD);
        run = 1'b1;
        count_to("t3b_retire5", 5, n);
        check("t3b_beq_untaken_pc", pc_out, 32'h14);
        wait_halt("t3b_halt");
        check("t3b_retired", 32'(retired), 32'd8);
        check("t3b_sb_empty", 32'(sb_q.size()), 32'd0);

        // T5: reset while a load is waiting on dmem
        do_reset();
        dwait = 10;
        imem[0] = f_i(3'b100, 5'd1, 5'd0, 12'd9);
        imem[1] = f_i(3'b101, 5'd5, 5'd0, 12'd0);
        run = 1'b1;
        n = 0;
        while (!dmem_req && n < 50) begin tick(); n++; end
        check("t5_dreq_up", 32'(dmem_req), 32'd1);
        tick();
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_dreq_drop", 32'(dmem_req), 32'd0);
        check("t5_pc", pc_out, 32'h0);
        check("t5_retired", 32'(retired), 32'd0);
        check("t5_opcode", 32'(Opcode), 32'd0);
        tick();
        rst = 1'b1;
        dwait = 0;
        tick(); tick();
        check("t5_idle", 32'(imem_req), 32'd0);
        imem[0] = f_s(3'b110, 5'd0, 5'd1, 12'd0);
        imem[1] = f_s(3'b110, 5'd0, 5'd5, 12'd4);
        imem[2] = 32'hFFFF_FFFF;
        push_st(32'd0, 32'd0);
        push_st(32'd4, 32'd0);
        run = 1'b1;
        wait_halt("t5_halt");
        check("t5_retired_after", 32'(retired), 32'd2);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // T6b: run dropped during the 2nd instruction
        do_reset();
        for (int i = 0; i < 5; i++) imem[i] = f_i(3'b100, 5'd1, 5'd1, 12'd1);
        run = 1'b1;
        count_to("t6_retire1", 1, n);
        run = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i > 4 && imem_req) req_seen++;
        end
        check("t6_stop_retired", 32'(retired), 32'd2);
        check("t6_stop_no_fetch", 32'(req_seen), 32'd0);
        check("t6_stop_pc", pc_out, 32'h8);
        check("t6_stop_not_halted", 32'(halted), 32'd0);

        // T6a: 2-bit counter saturates
        do_reset();
        for (int i = 0; i < 5; i++) imem[i] = f_i(3'b100, 5'd1, 5'd1, 12'd1);
        run2 = 1'b1;
        n = 0;
        while (!halted2 && n < 100) begin tick(); n++; end
        check("t6_sat_halt", 32'(halted2), 32'd1);
        check("t6_sat_retired", 32'(retired2), 32'd3);
        check("t6_sat_pc", pc_out2, 32'h14);
        run2 = 1'b0;

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
